stimulus_scheduler: RTL

//  Captures rising edges on the external stimulus lines and queues them as pending events.

---
 rtl/stimulus_scheduler.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/stimulus_scheduler.sv
// stimulus_scheduler
//   Detects rising edges on synchronised stimulus lines and queues each one as
//   a pending event. On every model tick it grants at most one pending event.
//   Selection is round-robin, and a line that has just been granted is blocked
//   for a cooldown period. The one-hot grant pulses replace raw input levels,
//   so downstream saturating counters never see held or bouncing inputs.
//
// Optional feature macro: STIM_DROP_CNT_EN
//   When defined, the design adds the saturating output dropped_cnt[7:0].
//
// Ports
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   tick         1-cycle strobe, one per model heartbeat
//   enable       0 flushes the queue and cooldowns and blocks grants
//   stimuli      stimulus levels, already synchronised to clk
//   grant        one-hot grant pulse, 1 clk wide
//   grant_valid  high in the same cycle as grant
//   grant_idx    index of the last granted line (holds between grants)
//   pending      queued-event bitmap
//   cooling      1 where the line's cooldown counter is non-zero
//   dropped_cnt  (STIM_DROP_CNT_EN only) count of cycles with a discarded rise
module stimulus_scheduler #(
    parameter int unsigned N_STIM   = 7,
    parameter int unsigned COOLDOWN = 8,
    parameter int unsigned CD_W     = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              tick,
    input  logic              enable,
    input  logic [N_STIM-1:0] stimuli,
    output logic [N_STIM-1:0] grant,
    output logic              grant_valid,
    output logic [2:0]        grant_idx,
    output logic [N_STIM-1:0] pending,
    output logic [N_STIM-1:0] cooling
`ifdef STIM_DROP_CNT_EN
    ,
    output logic [7:0]        dropped_cnt
`endif
);

    localparam int unsigned IDX_W = (N_STIM > 1) ? $clog2(N_STIM) : 1;
    localparam logic [N_STIM-1:0] ONE_HOT0 = N_STIM'(1);

    logic [N_STIM-1:0] prev_q;
    logic [2:0]        rr_ptr_q;
    logic [CD_W-1:0]   cd_q    [N_STIM];
    logic [CD_W-1:0]   cd_next [N_STIM];

    logic [N_STIM-1:0] rise_c;
    logic [N_STIM-1:0] cd_nz_c;
    logic [N_STIM-1:0] grant_oh_c;
    logic [N_STIM-1:0] drop_c;
    logic [N_STIM-1:0] pend_next;
    logic [N_STIM-1:0] cool_next;
    logic [2:0]        sel_idx_c;
    logic [2:0]        rr_next;
    logic              fire_c;

    // Edge detect and cooldown status.
    always_comb begin
        rise_c = stimuli & ~prev_q;
        for (int unsigned i = 0; i < N_STIM; i++) begin
            cd_nz_c[i] = (cd_q[i] != '0);
        end
    end

    // Round-robin scan of pending, starting at rr_ptr and wrapping at N_STIM.
    always_comb begin
        logic [3:0] pos;
        logic       found;
        sel_idx_c = '0;
        found     = 1'b0;
        pos       = '0;
        for (int unsigned off = 0; off < N_STIM; off++) begin
            pos = 4'(rr_ptr_q) + 4'(off);
            if (pos >= 4'(N_STIM)) begin
                pos = pos - 4'(N_STIM);
            end
            if (!found && pending[pos[IDX_W-1:0]]) begin
                found     = 1'b1;
                sel_idx_c = 3'(pos);
            end
        end
    end

    // Grant decision, queue update and cooldown update for this edge.
    always_comb begin
        fire_c     = tick & enable & (|pending);
        grant_oh_c = fire_c ? (ONE_HOT0 << sel_idx_c) : '0;
        rr_next    = rr_ptr_q;
        if (fire_c) begin
            rr_next = (sel_idx_c == 3'(N_STIM - 1)) ? 3'd0 : (sel_idx_c + 3'd1);
        end

        // A rise is lost if disabled, cooling, or colliding with its own grant.
        drop_c    = rise_c & ({N_STIM{~enable}} | cd_nz_c | grant_oh_c);
        pend_next = enable ? ((pending & ~grant_oh_c) | (rise_c & ~drop_c)) : '0;

        for (int unsigned i = 0; i < N_STIM; i++) begin
            cd_next[i] = cd_q[i];
            if (!enable) begin
                cd_next[i] = '0;
            end else if (grant_oh_c[i]) begin
                cd_next[i] = CD_W'(COOLDOWN);
            end else if (tick && cd_nz_c[i]) begin
                cd_next[i] = cd_q[i] - CD_W'(1);
            end
            cool_next[i] = (cd_next[i] != '0);
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q      <= '1;
            rr_ptr_q    <= '0;
            pending     <= '0;
            cooling     <= '0;
            grant       <= '0;
            grant_valid <= 1'b0;
            grant_idx   <= '0;
            for (int unsigned i = 0; i < N_STIM; i++) begin
                cd_q[i] <= '0;
            end
        end else begin
            prev_q      <= stimuli;
            rr_ptr_q    <= rr_next;
            pending     <= pend_next;
            cooling     <= cool_next;
            grant       <= grant_oh_c;
            grant_valid <= fire_c;
            if (fire_c) begin
                grant_idx <= sel_idx_c;
            end
            for (int unsigned i = 0; i < N_STIM; i++) begin
                cd_q[i] <= cd_next[i];
            end
        end
    end

`ifdef STIM_DROP_CNT_EN
    // Saturating count of cycles in which at least one rise was discarded.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dropped_cnt <= '0;
        end else if ((|drop_c) && (dropped_cnt != 8'hFF)) begin
            dropped_cnt <= dropped_cnt + 8'd1;
        end
    end
`endif

endmodule
